// File: rtl/traffic_pkg.sv
// Shared types and helpers for the intersection phase controller.
//   light_t : lamp encoding driven onto the light_a / light_b outputs
//   state_t : controller phase, value doubles as the phase debug code
//   max_of  : larger of two unsigned values, used to size counters
package traffic_pkg;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10
  } light_t;

  typedef enum logic [2:0] {
    A_GREEN   = 3'd0,
    A_YELLOW  = 3'd1,
    ALLRED_AB = 3'd2,
    B_GREEN   = 3'd3,
    B_YELLOW  = 3'd4,
    ALLRED_BA = 3'd5,
    PED_WALK  = 3'd6
  } state_t;

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Tick counter for the current phase.
//   clk, reset : clock, asynchronous active-high reset
//   en         : count enable (divider tick)
//   clr        : synchronous clear, wins over en
//   limit      : saturation value of the count
//   n          : count + 1, the value the controller evaluates this tick
module phase_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W:0]   n
);

  logic [CNT_W-1:0] count;

  // One bit wider than count so count+1 never wraps before the limit check.
  assign n = {1'b0, count} + (CNT_W+1)'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (n > {1'b0, limit}) ? limit : n[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/traffic_sequencer.sv
// Two-road intersection phase controller with pedestrian crossing.
// Road A rests in green; road B and the crossing are served on demand.
//   clk, reset  : clock, asynchronous active-high reset
//   tick        : one-clk enable pulse from the clock divider
//   sa, sb      : vehicle sensors for roads A and B
//   ped_req     : pedestrian button, latched into ped_pending
//   light_a/_b  : registered lamp outputs (light_t)
//   ped_walk    : walk lamp
//   ped_pending : latched request not yet served
//   phase       : current state code
module traffic_sequencer
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_MIN_TICKS = 3,
  parameter int unsigned GREEN_MAX_TICKS = 6,
  parameter int unsigned YELLOW_TICKS    = 2,
  parameter int unsigned ALLRED_TICKS    = 1,
  parameter int unsigned WALK_TICKS      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       sa,
  input  logic       sb,
  input  logic       ped_req,
  output light_t     light_a,
  output light_t     light_b,
  output logic       ped_walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  localparam int unsigned MAX_TICKS = max_of(max_of(max_of(GREEN_MIN_TICKS, GREEN_MAX_TICKS),
                                                    max_of(YELLOW_TICKS, ALLRED_TICKS)),
                                             WALK_TICKS);
  localparam int unsigned CNT_W = $clog2(MAX_TICKS) + 1;

  localparam logic [CNT_W:0]   N_GMIN  = (CNT_W+1)'(GREEN_MIN_TICKS);
  localparam logic [CNT_W:0]   N_GMAX  = (CNT_W+1)'(GREEN_MAX_TICKS);
  localparam logic [CNT_W:0]   N_YEL   = (CNT_W+1)'(YELLOW_TICKS);
  localparam logic [CNT_W:0]   N_ARED  = (CNT_W+1)'(ALLRED_TICKS);
  localparam logic [CNT_W:0]   N_WALK  = (CNT_W+1)'(WALK_TICKS);
  localparam logic [CNT_W-1:0] LIM_ALL = CNT_W'(MAX_TICKS);
  localparam logic [CNT_W-1:0] LIM_AG  = CNT_W'(GREEN_MAX_TICKS);

  state_t           state, state_nx;
  logic             clr;
  logic [CNT_W-1:0] limit;
  logic [CNT_W:0]   n;
  light_t           la_nx, lb_nx;
  logic             walk_nx;
  logic             sa_unused;

  // Road A sensor has no effect on sequencing.
  assign sa_unused = sa;

  assign phase = state;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .en    (tick),
    .clr   (clr),
    .limit (limit),
    .n     (n)
  );

  always_comb begin
    state_nx = state;
    limit    = LIM_ALL;
    case (state)
      A_GREEN: begin
        limit = LIM_AG;
        if (tick && n >= N_GMIN && (sb || ped_pending)) state_nx = A_YELLOW;
      end
      A_YELLOW:  if (tick && n == N_YEL) state_nx = ALLRED_AB;
      ALLRED_AB: if (tick && n == N_ARED) state_nx = ped_pending ? PED_WALK : B_GREEN;
      B_GREEN: begin
        if (tick && (n == N_GMAX || (n >= N_GMIN && (!sb || ped_pending))))
          state_nx = B_YELLOW;
      end
      B_YELLOW:  if (tick && n == N_YEL) state_nx = ALLRED_BA;
      ALLRED_BA: if (tick && n == N_ARED) state_nx = ped_pending ? PED_WALK : A_GREEN;
      PED_WALK:  if (tick && n == N_WALK) state_nx = A_GREEN;
      default:   state_nx = ALLRED_BA;
    endcase
    // Every transition (including illegal-code recovery) restarts the phase count.
    clr = (state_nx != state);
  end

  // Lamp decode from the next state so outputs register on the same edge as state.
  always_comb begin
    la_nx   = RED;
    lb_nx   = RED;
    walk_nx = 1'b0;
    case (state_nx)
      A_GREEN:  la_nx   = GREEN;
      A_YELLOW: la_nx   = YELLOW;
      B_GREEN:  lb_nx   = GREEN;
      B_YELLOW: lb_nx   = YELLOW;
      PED_WALK: walk_nx = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ALLRED_BA;
      light_a     <= RED;
      light_b     <= RED;
      ped_walk    <= 1'b0;
      ped_pending <= 1'b0;
    end else begin
      state    <= state_nx;
      light_a  <= la_nx;
      light_b  <= lb_nx;
      ped_walk <= walk_nx;
      // Entry into the walk phase consumes the request, including one arriving that cycle.
      if (state_nx == PED_WALK && state != PED_WALK) ped_pending <= 1'b0;
      else if (ped_req && state != PED_WALK)        ped_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_traffic_sequencer.sv
module tb_traffic_sequencer;

  localparam int L_RED    = 0;
  localparam int L_YELLOW = 1;
  localparam int L_GREEN  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b1;
  logic       sa = 1'b0;
  logic       sb = 1'b0;
  logic       ped_req = 1'b0;
  logic [1:0] light_a, light_b;
  logic       ped_walk, ped_pending;
  logic [2:0] phase;

  int errors = 0;
  int checks = 0;

  traffic_sequencer #(
    .GREEN_MIN_TICKS (3),
    .GREEN_MAX_TICKS (6),
    .YELLOW_TICKS    (2),
    .ALLRED_TICKS    (1),
    .WALK_TICKS      (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .sa          (sa),
    .sb          (sb),
    .ped_req     (ped_req),
    .light_a     (light_a),
    .light_b     (light_b),
    .ped_walk    (ped_walk),
    .ped_pending (ped_pending),
    .phase       (phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    tick    = 1'b1;
    sa      = 1'b0;
    sb      = 1'b0;
    ped_req = 1'b0;
    step();
    check("rst_phase", phase, 5);
    check("rst_light_a", light_a, L_RED);
    check("rst_light_b", light_b, L_RED);
    check("rst_walk", ped_walk, 0);
    check("rst_pending", ped_pending, 0);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    assert (!(light_a != 2'(L_RED) && light_b != 2'(L_RED)))
    else begin
      errors++;
      $display("FAIL no_conflict: light_a=%0d light_b=%0d", light_a, light_b);
    end
  end

  int exp2[13] = '{0, 0, 0, 1, 1, 2, 3, 3, 3, 4, 4, 5, 0};
  int exp3[16] = '{0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 3, 3, 4, 4, 5, 0};
  int exp4_ph[10] = '{0, 0, 1, 1, 2, 6, 6, 6, 6, 0};
  int exp4_pp[10] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
  int exp4_wk[10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0};

  initial begin
    // Idle: one tick of all-red, then A rests in green with a saturated count.
    do_reset();
    step();
    check("s1_phase_first", phase, 0);
    check("s1_light_a", light_a, L_GREEN);
    check("s1_light_b", light_b, L_RED);
    for (int unsigned i = 0; i < 20; i++) step();
    check("s1_phase_hold", phase, 0);
    check("s1_count_sat", 32'(dut.u_timer.count), 6);

    // B demand, dropped after B green's 2nd tick: B exits at minimum green.
    do_reset();
    sb = 1'b1;
    for (int unsigned i = 0; i < 13; i++) begin
      step();
      check($sformatf("s2_phase_%0d", i), phase, 32'(exp2[i]));
      if (i == 8) sb = 1'b0;
    end

    // B demand held: B green capped at maximum.
    do_reset();
    sb = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      step();
      check($sformatf("s3_phase_%0d", i), phase, 32'(exp3[i]));
      if (exp3[i] == 3) check($sformatf("s3_light_b_%0d", i), light_b, L_GREEN);
      if (exp3[i] == 4) check($sformatf("s3_light_b_%0d", i), light_b, L_YELLOW);
    end
    sb = 1'b0;

    // Pedestrian request with no B traffic; request during walk is ignored.
    do_reset();
    step();
    check("s4_phase_first", phase, 0);
    ped_req = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      step();
      if (i == 0) ped_req = 1'b0;
      if (i == 5) ped_req = 1'b1;
      if (i == 6) ped_req = 1'b0;
      check($sformatf("s4_phase_%0d", i), phase, 32'(exp4_ph[i]));
      check($sformatf("s4_pending_%0d", i), ped_pending, 32'(exp4_pp[i]));
      check($sformatf("s4_walk_%0d", i), ped_walk, 32'(exp4_wk[i]));
    end

    // Sparse ticks: state and count move only on tick cycles.
    do_reset();
    sb = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      tick = (i % 4 == 0);
      step();
      check($sformatf("s5_phase_%0d", i), phase, (i >= 12) ? 1 : 0);
      check($sformatf("s5_count_%0d", i), 32'(dut.u_timer.count),
            (i < 4) ? 0 : (i < 8) ? 1 : (i < 12) ? 2 : 0);
    end
    tick = 1'b1;

    // Asynchronous reset in the middle of B green.
    do_reset();
    sb = 1'b1;
    for (int unsigned i = 0; i < 7; i++) step();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    check("s6_phase_pre", phase, 3);
    check("s6_pending_pre", ped_pending, 1);
    #3;
    reset = 1'b1;
    #1;
    check("s6_phase_async", phase, 5);
    check("s6_light_a_async", light_a, L_RED);
    check("s6_light_b_async", light_b, L_RED);
    check("s6_pending_async", ped_pending, 0);
    check("s6_walk_async", ped_walk, 0);
    #2;
    reset = 1'b0;
    sb = 1'b0;
    step();
    check("s6_phase_after", phase, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_sequencer.md
Name: traffic_sequencer

Overview:
Phase controller for a two-road intersection with main road A, side road B and a pedestrian crossing. It advances only on the one-cycle tick pulse from the existing clock divider and counts ticks per phase. It drives the A, B and walk signal outputs using vehicle-sensor demand and a latched pedestrian request. Road A rests in green when nothing else is demanding service.

Parameters:
GREEN_MIN_TICKS, 3, minimum green duration for either road, in ticks (>=1)
GREEN_MAX_TICKS, 6, maximum B green duration; saturation value of the A-green counter (>= GREEN_MIN_TICKS)
YELLOW_TICKS, 2, yellow duration for either road (>=1)
ALLRED_TICKS, 1, all-red clearance duration (>=1)
WALK_TICKS, 4, pedestrian walk duration (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
tick  input  1  one-clk-wide enable pulse from the clock divider
sa  input  1  vehicle present on road A (synchronous to clk)
sb  input  1  vehicle present on road B (synchronous to clk)
ped_req  input  1  pedestrian button (synchronous to clk, any width)
light_a  output  2  road A light (light_t)
light_b  output  2  road B light (light_t)
ped_walk  output  1  walk lamp
ped_pending  output  1  latched, unserved pedestrian request
phase  output  3  current state encoding, for debug and LEDs

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Reset forces, immediately and without a clock edge: state ALLRED_BA, count=0, ped_pending=0, light_a=RED, light_b=RED, ped_walk=0.
- Moore outputs, registered: they change on the same edge as the state.
- States and phase codes:
  - A_GREEN=0: A=GREEN, B=RED
  - A_YELLOW=1: A=YELLOW, B=RED
  - ALLRED_AB=2: RED/RED
  - B_GREEN=3: A=RED, B=GREEN
  - B_YELLOW=4: A=RED, B=YELLOW
  - ALLRED_BA=5: RED/RED
  - PED_WALK=6: RED/RED, ped_walk=1
- Counting: count = ticks seen since entering the state. On a cycle with tick=1 the FSM evaluates n = count+1.
  - If the exit rule holds: move to the next state and clear count.
  - Otherwise: count <= n.
  - With tick=0, nothing changes except the ped_pending latch.
- Exit rules (all evaluated on tick cycles only):
  - A_GREEN: leave to A_YELLOW when n >= GREEN_MIN_TICKS and (sb | ped_pending). Otherwise hold; count saturates at GREEN_MAX_TICKS. sa is informational only.
  - A_YELLOW: after n == YELLOW_TICKS, go to ALLRED_AB.
  - ALLRED_AB: after n == ALLRED_TICKS, go to PED_WALK if ped_pending, else B_GREEN.
  - B_GREEN: leave to B_YELLOW when n == GREEN_MAX_TICKS, or when n >= GREEN_MIN_TICKS and (!sb | ped_pending).
  - B_YELLOW: after n == YELLOW_TICKS, go to ALLRED_BA.
  - ALLRED_BA: after n == ALLRED_TICKS, go to PED_WALK if ped_pending, else A_GREEN.
  - PED_WALK: after n == WALK_TICKS, go to A_GREEN.
- Pedestrian latch:
  - ped_pending sets on any cycle with ped_req=1 outside PED_WALK.
  - It clears on the edge entering PED_WALK. A ped_req on that same cycle is absorbed and does not re-set the latch.
  - ped_req during PED_WALK is ignored.
- The counter width is clog2 of the largest parameter plus 1. It never wraps.
- Illegal state code 7 recovers to ALLRED_BA on the next edge.
- Conflicting greens or yellows (A and B both non-RED) must never occur. The bench checks this with an assertion.

Decomposition:
- Package traffic_pkg holds:
  - light_t enum: RED=2'b00, YELLOW=2'b01, GREEN=2'b10; 2'b11 unused
  - state_t enum with the phase codes above
  - a max-of-params helper function
- One sub-module, phase_timer: a tick-enabled counter with synchronous clear, saturation limit and asynchronous reset. It outputs count+1. The FSM does the comparisons.

Test Plan:
All scenarios use default parameters.
- Reset with tick every cycle, sa=sb=ped_req=0 -> RED/RED, phase=5 for 1 tick, then A_GREEN. Holds A_GREEN for 20 ticks; count saturates at 6.
- sb=1 from the first A_GREEN tick, then drops after B_GREEN's 2nd tick -> phase sequence: 0 (3 ticks), 1 (2), 2 (1), 3; B_GREEN exits on its 3rd tick (min).
- sb held high through B_GREEN -> B_GREEN lasts exactly 6 ticks, then 4 (2 ticks), 5 (1 tick), 0.
- One-cycle ped_req during A_GREEN, sb=0 -> ped_pending=1 on the next edge; 0→1→2→6; ped_walk=1 for 4 ticks; ped_pending=0 on PED_WALK entry; then returns to 0.
- Tick every 4th cycle -> state and count change only on tick cycles. Outputs are stable for the 3 intervening cycles.
- reset pulsed mid-B_GREEN between edges -> light_a=light_b=RED, phase=5, ped_pending=0 immediately, before the next clk edge.
